bcd_converter: RTL and testbench
================================

# bcd_converter

Sequential binary-to-BCD converter that produces the digit and flag inputs consumed by the calculator's seven-segment display decoder. It accepts an 8-bit unsigned ALU result plus the Zero/Overflow/Carry_out flags on a start pulse. It converts the value with an iterative shift-and-add-3 (double-dabble) loop. It then presents Units, Tens and Hundreds with the flags captured alongside them, all updated in the same cycle.

## Interface
- No parameters; data width is fixed at 8 bits, so the maximum value is 255 and Hundreds is 0..2.
- clock  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- Start  input  1  request a conversion; sampled only in IDLE.
- Value  input  8  unsigned binary operand; captured when Start is accepted.
- Zero_in, Overflow_in, Carry_in  input  1 each  ALU flags; captured when Start is accepted.
- Busy  output  1  high whenever the state is not IDLE.
- Done  output  1  one-cycle pulse; high while in DONE.
- Units, Tens  output  4 each  BCD digits 0..9.
- Hundreds  output  2  BCD hundreds digit, 0..2.
- Zero, Overflow, Carry_out  output  1 each  flags paired with the current digits.

## Operation
- States:
  - IDLE: Start=1 moves to SHIFT.
  - SHIFT: loops 8 iterations using a 3-bit counter.
  - DONE: always returns to IDLE after one cycle.
- Load (IDLE with Start=1):
  - Binary shift register <= Value.
  - BCD scratch {H[1:0],T[3:0],U[3:0]} <= 0.
  - Counter <= 0.
  - Flag holding registers <= Zero_in, Overflow_in, Carry_in.
- SHIFT iteration:
  - Correct: if U >= 5 then U += 3; if T >= 5 then T += 3 (4-bit arithmetic). H never reaches 5 and gets no correction.
  - Shift left: {H,T,U,bin} shifted by 1. The MSB of bin enters U[0], U[3] enters T[0], T[3] enters H[0].
  - Counter increments each iteration.
- Last iteration (counter=7):
  - The corrected and shifted scratch is written directly into Units/Tens/Hundreds.
  - Held flags are written into Zero/Overflow/Carry_out in the same edge.
  - State moves to DONE.
- Outputs hold their last result until the next conversion completes, including while Busy. They are never partially updated.
- Start is ignored in SHIFT and in DONE; a request there is not queued.
- Value and flag inputs may change freely after the load edge.

## Timing
- Reset (reset_n=0 at an edge):
  - State goes to IDLE and the counter and scratch are cleared.
  - Busy=0, Done=0.
  - Units=0, Tens=0, Hundreds=0, Zero=0, Overflow=0, Carry_out=0.
- Reset wins over any other event in the same edge.
- Reset during SHIFT or DONE aborts the conversion. No Done pulse follows, and outputs read 0.
- Edge sequence, with E0 the edge that samples Start=1 in IDLE:
  - E1..E8: shift iterations.
  - E8: outputs loaded; Done=1 and Busy=1 during the cycle after E8.
  - E9: back to IDLE with Busy=0.
- Busy rises after E0 and falls after E9.
- Result latency is 8 clocks from the accepting edge.
- Earliest next accepting edge is E10, so minimum period is 10 clocks per conversion.
- Start held high continuously gives back-to-back conversions every 10 clocks.

## Test plan
- Reset, then Value=0, Start pulse -> Done exactly 8 edges after acceptance; Units=0, Tens=0, Hundreds=0; Busy high for 9 cycles.
- Value=255 with Overflow_in=1, Carry_in=1 -> Hundreds=2, Tens=5, Units=5, Overflow=1, Carry_out=1, Zero=0, all in the Done cycle.
- Digit sweep: Value=199 -> 1/9/9; Value=100 -> 1/0/0; Value=9 -> 0/0/9; Value=59 -> 0/5/9. Also exhaustive 0..255 against a reference model.
- Start=1 with Value=42 at E0, then Start pulsed at E3 and in the Done cycle with Value=77 -> only 0/4/2 produced, one Done pulse, no second conversion.
- reset_n=0 at E4 of a conversion of Value=123 -> outputs all 0, Busy=0, no Done. A fresh Start with Value=123 then yields 1/2/3.
- Previous result 0/8/8; start a conversion of 200 and sample the outputs during E1..E7 -> they stay 0/8/8, then change to 2/0/0 exactly at E8.

Source files
------------

// File: rtl/bcd_converter.sv
// Sequential 8-bit binary to BCD converter (shift-and-add-3) feeding the seven-segment decoder.
// Digits and flags are registered together and change only when a conversion completes.
module bcd_converter (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       Start,
    input  logic [7:0] Value,
    input  logic       Zero_in,
    input  logic       Overflow_in,
    input  logic       Carry_in,
    output logic       Busy,
    output logic       Done,
    output logic [3:0] Units,
    output logic [3:0] Tens,
    output logic [1:0] Hundreds,
    output logic       Zero,
    output logic       Overflow,
    output logic       Carry_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [7:0]      bin_reg;
    logic [1:0][3:0] digit_reg;     // [0] = units, [1] = tens
    logic [1:0][3:0] digit_adj;
    logic            hund_lsb_reg;  // scratch H[1] is shifted out every iteration, so only H[0] is kept
    logic [2:0]      cnt_reg;
    logic [2:0]      flag_reg;      // {Zero, Overflow, Carry}
    logic [17:0]     shift_next;

    logic [3:0]      units_reg;
    logic [3:0]      tens_reg;
    logic [1:0]      hund_reg;
    logic [2:0]      out_flag_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_adj
            assign digit_adj[gi] = (digit_reg[gi] >= 4'd5) ? digit_reg[gi] + 4'd3 : digit_reg[gi];
        end
    endgenerate

    // {H[1:0], T, U, bin} after correction and one left shift
    assign shift_next = {hund_lsb_reg, digit_adj[1], digit_adj[0], bin_reg, 1'b0};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (Start) state_next = SHIFT;
            SHIFT:   if (cnt_reg == 3'd7) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            bin_reg      <= '0;
            digit_reg    <= '0;
            hund_lsb_reg <= 1'b0;
            cnt_reg      <= '0;
            flag_reg     <= '0;
            units_reg    <= '0;
            tens_reg     <= '0;
            hund_reg     <= '0;
            out_flag_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        bin_reg      <= Value;
                        digit_reg    <= '0;
                        hund_lsb_reg <= 1'b0;
                        cnt_reg      <= '0;
                        flag_reg     <= {Zero_in, Overflow_in, Carry_in};
                    end
                end
                SHIFT: begin
                    bin_reg      <= shift_next[7:0];
                    digit_reg    <= shift_next[15:8];
                    hund_lsb_reg <= shift_next[16];
                    cnt_reg      <= cnt_reg + 3'd1;
                    if (cnt_reg == 3'd7) begin
                        units_reg    <= shift_next[11:8];
                        tens_reg     <= shift_next[15:12];
                        hund_reg     <= shift_next[17:16];
                        out_flag_reg <= flag_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy      = (state_reg != IDLE);
    assign Done      = (state_reg == DONE);
    assign Units     = units_reg;
    assign Tens      = tens_reg;
    assign Hundreds  = hund_reg;
    assign Zero      = out_flag_reg[2];
    assign Overflow  = out_flag_reg[1];
    assign Carry_out = out_flag_reg[0];

endmodule

// File: tb/tb_bcd_converter.sv
// Directed bench for bcd_converter: timing, flags, hold behaviour, ignored starts, reset abort
// and an exhaustive 0..255 sweep against an arithmetic reference.
module tb_bcd_converter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       Start;
    logic [7:0] Value;
    logic       Zero_in, Overflow_in, Carry_in;
    logic       Busy, Done;
    logic [3:0] Units, Tens;
    logic [1:0] Hundreds;
    logic       Zero, Overflow, Carry_out;

    int n_vec  = 0;
    int n_miss = 0;

    // values captured in the Done cycle of the last convert() call
    int cap_bcd, cap_flags, cap_lat, cap_busy;

    always #5 clock = ~clock;

    bcd_converter dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .Start      (Start),
        .Value      (Value),
        .Zero_in    (Zero_in),
        .Overflow_in(Overflow_in),
        .Carry_in   (Carry_in),
        .Busy       (Busy),
        .Done       (Done),
        .Units      (Units),
        .Tens       (Tens),
        .Hundreds   (Hundreds),
        .Zero       (Zero),
        .Overflow   (Overflow),
        .Carry_out  (Carry_out)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int obs_bcd();
        return 32'({Hundreds, Tens, Units});
    endfunction

    function automatic int obs_flags();
        return 32'({Zero, Overflow, Carry_out});
    endfunction

    function automatic int ref_bcd(input int v);
        return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    // Launch one conversion, scramble inputs after the load edge, follow it back to IDLE.
    task automatic convert(input logic [7:0] v, input logic z, input logic o, input logic c);
        @(negedge clock);
        Value = v; Zero_in = z; Overflow_in = o; Carry_in = c; Start = 1'b1;
        @(posedge clock); #1;                       // E0
        Start = 1'b0;
        Value = 8'($urandom); {Zero_in, Overflow_in, Carry_in} = 3'($urandom);
        cap_lat = -1; cap_busy = 0; cap_bcd = -1; cap_flags = -1;
        for (int k = 1; k <= 20; k++) begin
            if (Busy) cap_busy++;
            @(posedge clock); #1;
            if (Done && cap_lat < 0) begin
                cap_lat   = k;
                cap_bcd   = obs_bcd();
                cap_flags = obs_flags();
            end
            if (!Busy) break;
        end
        if (cap_lat < 0) check("conv_timeout", 0, 1);
        $display("conv v=%0d -> bcd=%0h flags=%0b lat=%0d busy=%0d", v, cap_bcd, cap_flags, cap_lat, cap_busy);
    endtask

    initial begin
        int done_seen, busy_seen;
        logic [7:0] dir_v [4] = '{8'd199, 8'd100, 8'd9, 8'd59};
        int         dir_e [4] = '{32'h199, 32'h100, 32'h009, 32'h059};

        reset_n = 1'b0; Start = 1'b0; Value = '0;
        Zero_in = 1'b0; Overflow_in = 1'b0; Carry_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy",  32'(Busy), 0);
        check("rst_done",  32'(Done), 0);
        check("rst_bcd",   obs_bcd(), 0);
        check("rst_flags", obs_flags(), 0);
        @(negedge clock); reset_n = 1'b1;

        // Value 0 with Zero flag
        convert(8'd0, 1'b1, 1'b0, 1'b0);
        check("zero_lat",   cap_lat, 8);
        check("zero_busy",  cap_busy, 9);
        check("zero_bcd",   cap_bcd, 0);
        check("zero_flags", cap_flags, 3'b100);

        // 255 with overflow and carry
        convert(8'd255, 1'b0, 1'b1, 1'b1);
        check("max_lat",   cap_lat, 8);
        check("max_bcd",   cap_bcd, 32'h255);
        check("max_flags", cap_flags, 3'b011);

        for (int i = 0; i < 4; i++) begin
            convert(dir_v[i], 1'b0, 1'b0, 1'b0);
            check("sweep_bcd", cap_bcd, dir_e[i]);
        end

        // Start requests during SHIFT and DONE must be dropped
        @(negedge clock); Value = 8'd42; Start = 1'b1;
        @(posedge clock); #1; Start = 1'b0;          // E0
        repeat (2) @(posedge clock);                 // E2
        @(negedge clock); Value = 8'd77; Start = 1'b1;
        @(posedge clock); #1; Start = 1'b0;          // E3
        repeat (5) @(posedge clock);                 // E8
        #1;
        check("ign_done", 32'(Done), 1);
        check("ign_bcd",  obs_bcd(), 32'h042);
        @(negedge clock); Start = 1'b1;              // Done cycle
        @(posedge clock); #1; Start = 1'b0;          // E9
        check("ign_idle", 32'(Busy), 0);
        done_seen = 0; busy_seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clock); #1;
            if (Done) done_seen++;
            if (Busy) busy_seen++;
        end
        check("ign_no_done", done_seen, 0);
        check("ign_no_busy", busy_seen, 0);
        check("ign_hold",    obs_bcd(), 32'h042);
        $display("ignored-start sequence done");

        // Reset at E4 aborts a conversion of 123
        @(negedge clock); Value = 8'd123; Carry_in = 1'b1; Start = 1'b1;
        @(posedge clock); #1; Start = 1'b0; Carry_in = 1'b0;   // E0
        repeat (3) @(posedge clock);                 // E3
        @(negedge clock); reset_n = 1'b0;
        @(posedge clock); #1;                        // E4
        check("abort_bcd",   obs_bcd(), 0);
        check("abort_flags", obs_flags(), 0);
        check("abort_busy",  32'(Busy), 0);
        check("abort_done",  32'(Done), 0);
        @(negedge clock); reset_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clock); #1;
            if (Done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        $display("reset-abort sequence done");
        convert(8'd123, 1'b0, 1'b0, 1'b0);
        check("after_abort_bcd", cap_bcd, 32'h123);

        // Outputs hold 088 through E1..E7 and switch to 200 exactly at E8
        convert(8'd88, 1'b0, 1'b0, 1'b0);
        check("hold_pre", cap_bcd, 32'h088);
        @(negedge clock); Value = 8'd200; Start = 1'b1;
        @(posedge clock); #1; Start = 1'b0;          // E0
        for (int k = 1; k <= 7; k++) begin
            @(posedge clock); #1;
            check("hold_mid", obs_bcd(), 32'h088);
        end
        @(posedge clock); #1;                        // E8
        check("hold_e8_bcd",  obs_bcd(), 32'h200);
        check("hold_e8_done", 32'(Done), 1);
        @(posedge clock); #1;                        // E9
        check("hold_e9_busy", 32'(Busy), 0);
        $display("hold sequence done");

        // Exhaustive sweep against the arithmetic reference
        for (int v = 0; v < 256; v++) begin
            convert(8'(v), v[2], v[1], v[0]);
            check("exh_bcd",   cap_bcd, ref_bcd(v));
            check("exh_flags", cap_flags, v & 7);
            check("exh_lat",   cap_lat, 8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
